// File: rtl/ofifo_pkg.sv
// Shared constants and helpers for the output FIFO that aligns PE-array columns.
package ofifo_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 16;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  // The extra pointer MSB separates a full buffer from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_col.sv
// Single-lane circular FIFO with fall-through head and a sticky overflow flag.
// rd arrives already qualified by the row-level pop condition.
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] in,
  input  logic               rd,
  output logic [psum_bw-1:0] out,
  output logic               empty,
  output logic               full,
  output logic               ovf
);

  localparam int PW = ptr_width(depth);
  localparam int AW = PW - 1;

  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic               ovf_q, ovf_d;
  logic               push;
  logic [psum_bw-1:0] mem_q [depth];

  // Occupancy flags, accept decision and next pointer values.
  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    // A full lane may still take a push when the row pops in the same cycle.
    push   = wr && (!full || rd);
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = rd ? rptr_q + PW'(1) : rptr_q;
    ovf_d  = ovf_q || (wr && full && !rd);
  end

  // Pointer and error state; reset empties the lane immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= in;
    end
  end

  // Fall-through head, forced to zero while the lane is empty.
  always_comb begin
    out = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    ovf = ovf_q;
  end

endmodule

// File: rtl/ofifo.sv
// Output FIFO: per-column lanes filled independently, drained one whole row at a time.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*psum_bw-1:0] in,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic [1:0]             o_err
);

  logic [col-1:0] empty_v;
  logic [col-1:0] full_v;
  logic [col-1:0] ovf_v;
  logic           pop;
  logic           udf_q, udf_d;

  for (genvar g = 0; g < col; g++) begin : g_col
    ofifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[g]),
      .in    (in[g*psum_bw +: psum_bw]),
      .rd    (pop),
      .out   (out[g*psum_bw +: psum_bw]),
      .empty (empty_v[g]),
      .full  (full_v[g]),
      .ovf   (ovf_v[g])
    );
  end

  // Row-level combining: a row exists only when every lane has an entry.
  always_comb begin
    o_valid        = &(~empty_v);
    o_full         = |full_v;
    o_ready        = ~o_full;
    pop            = rd && o_valid;
    udf_d          = udf_q || (rd && !o_valid);
    o_err          = '0;
    o_err[ERR_OVF] = |ovf_v;
    o_err[ERR_UDF] = udf_q;
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      udf_q <= 1'b0;
    end else begin
      udf_q <= udf_d;
    end
  end

endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
- Output FIFO between the PE array's bottom row and the special-function/accumulate stage.
- Each array column pushes a finished psum independently, whenever that column's results emerge (columns are skewed in time).
- The block aligns the columns. It presents one full row of psums, one per column, only when every column has at least one entry.
- The downstream stage pops a whole row at once and feeds each lane as the FIFO-side operand of the accumulate/ReLU path.

Parameters:
- col, 8, number of array columns (lanes).
- psum_bw, 16, width of one psum entry.
- depth, 16, entries per column; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr  in  col  per-column push strobe; bit i pushes lane i.
- in  in  col*psum_bw  push data; lane i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
- rd  in  1  pops the head entry of every column together.
- out  out  col*psum_bw  head row, using the same lane packing as in.
- o_valid  out  1  every column is non-empty.
- o_full  out  1  at least one column is full.
- o_ready  out  1  no column is full (equal to ~o_full).
- o_err  out  2  sticky error flags: bit0 = overflow, bit1 = underflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - All read and write pointers go to 0.
  - out=0, o_valid=0, o_full=0, o_ready=1, o_err=0.
  - Storage array contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately, with no drain.
- Storage and pointers:
  - Each column is an independent circular buffer of depth entries.
  - Write and read pointers are $clog2(depth)+1 bits wide; the extra MSB distinguishes full from empty.
  - Column i is empty when wptr==rptr.
  - Column i is full when the index bits are equal and the MSBs differ.
  - Pointers wrap modulo 2*depth with no special handling.
- Write:
  - When wr[i]=1 and column i accepts, in lane i is stored at wptr_i and wptr_i increments.
  - Column i accepts if it is not full, or if it is full and a row pop occurs in the same cycle.
- Read (row pop):
  - A pop occurs when rd=1 and o_valid=1; every rptr_i increments together.
  - rd=1 while o_valid=0 is ignored: no pointer moves and o_err[1] is set.
- Output timing:
  - out is first-word fall-through: out lane i = mem_i[rptr_i] while column i is non-empty, otherwise 0.
  - out is combinational from registered state.
  - A write becomes visible on out/o_valid the cycle after the edge that stores it.
  - o_valid, o_full and o_ready are derived combinationally from pointer state, so they also have 1-cycle latency after the causing edge.
- Errors:
  - wr[i]=1 to a full column with no pop in the same cycle: the data is dropped, the pointer is held, and o_err[0] is set.
  - Both o_err bits clear only on reset.
- Simultaneous events:
  - Push and pop on a non-empty, non-full column: occupancy is unchanged.
  - Push to a full column together with a pop: accepted, and the column stays full.
  - Push to an empty column together with rd: the pop cannot occur (o_valid=0), so this is an underflow; the push is still stored.
- Throughput: one push per column per cycle and one row pop per cycle, with no bubbles.
- Data is stored verbatim; there is no arithmetic or sign handling.

Decomposition:
- Shared package:
  - default constants COL=8, PSUM_BW=16, OFIFO_DEPTH=16;
  - pointer-width function clog2(depth)+1;
  - error-bit index constants ERR_OVF=0, ERR_UDF=1.
- Sub-module ofifo_col: single-lane FIFO.
  - Interface: clk, reset, wr, in, rd (already gated by the row-pop condition), out, empty, full, ovf.
  - The top level instantiates col copies in a generate loop and does the row-level combining:
    - o_valid = AND of ~empty;
    - o_full = OR of full;
    - o_err = OR of the per-lane ovf flags, plus underflow detection.

Test Plan:
1. Reset check:
   - Assert reset=0 mid-stream after 5 pushes to all lanes.
   - Required: o_valid=0, out=0, o_err=0 immediately, without waiting for a clock edge. After release, the first pop returns only post-reset data.
2. Skewed fill:
   - Push lane i at cycle i with value 16'h0100+i, for col=8.
   - Required: o_valid stays 0 until the cycle after lane 7's push. out then equals {16'h0107,...,16'h0100}. rd=1 then gives o_valid=0 on the next cycle.
3. Full and overflow:
   - Push 16 entries to all lanes (0..15), then push 16'hDEAD on lane 3 with rd=0.
   - Required: o_full=1, o_ready=0, o_err[0]=1.
   - Sixteen pops return 0..15 in order, with no DEAD.
4. Full with simultaneous push and pop:
   - Full FIFO; assert wr=all and in=16'h00AA on every lane with rd=1.
   - Required: out advances to entry 1, o_full stays 1, o_err=0.
   - After draining, the last row equals 16'h00AA.
5. Underflow:
   - Empty FIFO, rd=1 for one cycle.
   - Required: o_err[1]=1 and the pointers are unchanged. A subsequent push/pop round-trip returns the correct data.
6. Wrap and stream:
   - 100 cycles of wr=all, rd=1 with an incrementing counter, after a 4-entry prefill.
   - Required: out equals the counter minus 4 on every cycle, and o_valid=1 throughout. This crosses the pointer wrap several times.
